// File: rtl/timer_bank_if.sv
// CPU-side memory-mapped bus into the timer bank.
// The master drives the address, data and strobes; the slave returns read data.
interface timer_bank_if;
  logic [15:0] A;
  logic [7:0]  Di;
  logic [7:0]  Do;
  logic        wr_n;
  logic        rd_n;
  logic        cs;

  modport master (output A, Di, wr_n, rd_n, cs, input Do);
  modport slave  (input A, Di, wr_n, rd_n, cs, output Do);
endinterface

// File: rtl/timer_bank.sv
// Multi-channel programmable up-counter timers sharing one free-running prescaler,
// with per-channel pending bits merged into a single interrupt request.
module timer_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFF80
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              int_ack,
  output logic              int_req,
  output logic [NUM_CH-1:0] int_vec,
  timer_bank_if.slave       bus
);
  typedef logic [WIDTH-1:0] cnt_t;

  logic [9:0]        psc_q;
  cnt_t              cnt_q    [NUM_CH];
  cnt_t              rld_q    [NUM_CH];
  logic [7:0]        buf_q    [NUM_CH];
  logic [7:0]        shadow_q [NUM_CH];
  logic [1:0]        rate_q   [NUM_CH];
  logic [NUM_CH-1:0] en_q, mode_q, ie_q, pend_q;
  logic [7:0]        reg_out_q;

  logic [15:0]       off;
  logic [2:0]        ch_sel, reg_sel;
  logic              hit, wr_hit, rd_strobe, rd_hit;
  logic [NUM_CH-1:0] sel, cnt_commit, tick, ovf, ack_sel;
  logic              ack_found;
  logic [7:0]        rd_val;

  function automatic logic rate_tick(input logic [1:0] rate, input logic [9:0] psc);
    case (rate)
      2'd0:    return 1'b1;
      2'd1:    return &psc[3:0];
      2'd2:    return &psc[5:0];
      default: return &psc;
    endcase
  endfunction

  function automatic logic [7:0] hi_byte(input cnt_t v);
    return 8'(16'(v) >> 8);
  endfunction

  assign off       = bus.A - BASE_ADDR;
  assign ch_sel    = off[5:3];
  assign reg_sel   = off[2:0];
  assign hit       = bus.cs && (bus.A >= BASE_ADDR) && (off < 16'(8 * NUM_CH));
  assign wr_hit    = hit && !bus.wr_n;
  assign rd_strobe = bus.cs && !bus.rd_n && bus.wr_n;
  assign rd_hit    = hit && rd_strobe;

  // A committing count write swallows that cycle's tick, so no overflow either.
  always_comb begin
    sel        = '0;
    cnt_commit = '0;
    tick       = '0;
    ovf        = '0;
    ack_sel    = '0;
    ack_found  = 1'b0;
    rd_val     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel[i]        = (ch_sel == 3'(i));
      cnt_commit[i] = wr_hit && sel[i] &&
                      (((WIDTH == 16) && (reg_sel == 3'd1)) ||
                       ((WIDTH != 16) && (reg_sel == 3'd0)));
      tick[i]       = en_q[i] && rate_tick(rate_q[i], psc_q) && !cnt_commit[i];
      ovf[i]        = tick[i] && (cnt_q[i] == '1);
      if (!ack_found && pend_q[i] && ie_q[i]) begin
        ack_sel[i] = int_ack;
        ack_found  = 1'b1;
      end
      if (hit && sel[i]) begin
        case (reg_sel)
          3'd0:    rd_val = cnt_q[i][7:0];
          3'd1:    rd_val = (WIDTH == 16) ? shadow_q[i] : 8'h00;
          3'd2:    rd_val = rld_q[i][7:0];
          3'd3:    rd_val = (WIDTH == 16) ? hi_byte(rld_q[i]) : 8'h00;
          3'd4:    rd_val = {3'b000, ie_q[i], rate_q[i], mode_q[i], en_q[i]};
          3'd5:    rd_val = {7'b0000000, pend_q[i]};
          default: rd_val = 8'h00;
        endcase
      end
    end
  end

  // Statement order encodes same-cycle precedence: writes follow the tick,
  // and an overflow set follows both W1C and acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      psc_q     <= '0;
      reg_out_q <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      ie_q      <= '0;
      pend_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        rld_q[i]    <= '0;
        buf_q[i]    <= '0;
        shadow_q[i] <= '0;
        rate_q[i]   <= '0;
      end
    end else begin
      psc_q <= psc_q + 10'd1;
      if (rd_strobe) reg_out_q <= rd_val;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (tick[i]) cnt_q[i] <= ovf[i] ? rld_q[i] : cnt_q[i] + cnt_t'(1);
        if (ovf[i] && mode_q[i]) en_q[i] <= 1'b0;
        if (rd_hit && sel[i] && (reg_sel == 3'd0)) shadow_q[i] <= hi_byte(cnt_q[i]);
        if (wr_hit && sel[i]) begin
          case (reg_sel)
            3'd0: if (WIDTH == 16) buf_q[i] <= bus.Di; else cnt_q[i] <= cnt_t'(bus.Di);
            3'd1: if (WIDTH == 16) cnt_q[i] <= cnt_t'({bus.Di, buf_q[i]});
            3'd2: if (WIDTH == 16) buf_q[i] <= bus.Di; else rld_q[i] <= cnt_t'(bus.Di);
            3'd3: if (WIDTH == 16) rld_q[i] <= cnt_t'({bus.Di, buf_q[i]});
            3'd4: begin
              en_q[i]   <= bus.Di[0];
              mode_q[i] <= bus.Di[1];
              rate_q[i] <= bus.Di[3:2];
              ie_q[i]   <= bus.Di[4];
            end
            3'd5: if (bus.Di[0]) pend_q[i] <= 1'b0;
            default: ;
          endcase
        end
        if (ack_sel[i]) pend_q[i] <= 1'b0;
        if (ovf[i])     pend_q[i] <= 1'b1;
      end
    end
  end

  assign bus.Do  = bus.cs ? reg_out_q : 8'h00;
  assign int_req = |(pend_q & ie_q);
  assign int_vec = pend_q;
endmodule
